// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// Optional IF_STALL_CNT_EN adds saturating stall/bubble performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [4:0]  ifid_rs,
`ifdef IF_STALL_CNT_EN
  output logic [4:0]  ifid_rt,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`else
  output logic [4:0]  ifid_rt
`endif
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;

  logic        run;
  logic        advance;
  logic [31:0] pc_plus4;

  assign run      = (state_q == ST_RUN);
  assign advance  = run & imem_ready & pc_write & ifid_write;
  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = ST_RUN;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    if (run) begin
      if (branch_taken) begin
        // A resolved branch is older than any load-use stall, so it wins.
        pc_d    = {branch_target[31:2], 2'b00};
        instr_d = NOP_INSTR;
        ipc_d   = 32'd0;
        ipc4_d  = 32'd0;
        valid_d = 1'b0;
      end else if (advance) begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        ipc4_d  = pc_plus4;
        valid_d = 1'b1;
      end else if (ifid_write) begin
        // Nothing fetched this cycle: hand decode a bubble, PC waits for the refetch.
        instr_d = NOP_INSTR;
        ipc_d   = 32'd0;
        ipc4_d  = 32'd0;
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = run;
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc4   = ipc4_q;
  assign ifid_valid = valid_q;
  assign ifid_rs    = instr_q[25:21];
  assign ifid_rt    = instr_q[20:16];

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        stall_inc, bubble_inc;

  assign stall_inc  = run & ~branch_taken & ~ifid_write;
  assign bubble_inc = run & (branch_taken | (~advance & ifid_write));

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bubble_inc && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed vectors push expected IF/ID state,
// a monitor compares one entry after every rising edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_write, ifid_write, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_instr, ifid_pc, ifid_pc4;
  logic [4:0]  ifid_rs, ifid_rt;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    bit          chk_pc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .ifid_rs      (ifid_rs),
`ifdef IF_STALL_CNT_EN
    .ifid_rt      (ifid_rt),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
`else
    .ifid_rt      (ifid_rt)
`endif
  );

  // Memory: word 0 is a lw, every other word is tagged with its address; garbage while not ready.
  always_comb begin
    if (!imem_ready)           imem_rdata = 32'hDEAD_BEEF;
    else if (imem_addr == 0)   imem_rdata = 32'h8C22_0004;
    else                       imem_rdata = 32'hA000_0000 | imem_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and record what IF must look like after the next rising edge.
  task automatic cycle(input logic pw, input logic iw, input logic bt, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic [31:0] e_pc4, input logic e_valid,
                       input bit e_chk_pc);
    exp_t e;
    pc_write      = pw;
    ifid_write    = iw;
    branch_taken  = bt;
    branch_target = tgt;
    imem_ready    = rdy;
    e.addr = e_addr; e.instr = e_instr; e.pc = e_pc; e.pc4 = e_pc4;
    e.valid = e_valid; e.chk_pc = e_chk_pc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},   32'd0);
    check({tag, "_addr"},  imem_addr,           32'd0);
    check({tag, "_instr"}, ifid_instr,          32'd0);
    check({tag, "_pc"},    ifid_pc,             32'd0);
    check({tag, "_pc4"},   ifid_pc4,            32'd0);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imem_req",   {31'd0, imem_req},   32'd1);
        check("imem_addr",  imem_addr,           e.addr);
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
        check("ifid_instr", ifid_instr,          e.instr);
        if (e.chk_pc) begin
          check("ifid_pc",  ifid_pc,             e.pc);
          check("ifid_pc4", ifid_pc4,            e.pc4);
          check("ifid_rs",  {27'd0, ifid_rs},    {27'd0, e.instr[25:21]});
          check("ifid_rt",  {27'd0, ifid_rt},    {27'd0, e.instr[20:16]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    pc_write = 1'b1; ifid_write = 1'b1; branch_taken = 1'b0;
    branch_target = 32'd0; imem_ready = 1'b1;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    check("boot_addr", imem_addr, 32'd0);

    //    pw iw bt target        rdy addr          instr          pc            pc4           v  chk
    cycle(1, 1, 0, 32'd0,        1, 32'd0,        32'd0,         32'd0,        32'd0,        0, 1); // boot edge
    cycle(1, 1, 0, 32'd0,        1, 32'd4,        32'h8C22_0004, 32'd0,        32'd4,        1, 1);
    cycle(1, 1, 0, 32'd0,        1, 32'd8,        32'hA000_0004, 32'd4,        32'd8,        1, 1);
    cycle(0, 0, 0, 32'd0,        1, 32'd8,        32'hA000_0004, 32'd4,        32'd8,        1, 1); // load-use
    cycle(1, 1, 0, 32'd0,        1, 32'd12,       32'hA000_0008, 32'd8,        32'd12,       1, 1);
    cycle(1, 1, 0, 32'd0,        1, 32'd16,       32'hA000_000C, 32'd12,       32'd16,       1, 1);
    cycle(1, 1, 0, 32'd0,        0, 32'd16,       32'd0,         32'd0,        32'd0,        0, 0); // mem wait
    cycle(1, 1, 0, 32'd0,        0, 32'd16,       32'd0,         32'd0,        32'd0,        0, 0);
    cycle(1, 1, 0, 32'd0,        0, 32'd16,       32'd0,         32'd0,        32'd0,        0, 0);
    cycle(1, 1, 0, 32'd0,        1, 32'd20,       32'hA000_0010, 32'd16,       32'd20,       1, 1);
    cycle(0, 0, 1, 32'h103,      1, 32'h100,      32'd0,         32'd0,        32'd0,        0, 1); // branch in stall
    cycle(1, 1, 0, 32'd0,        1, 32'h104,      32'hA000_0100, 32'h100,      32'h104,      1, 1);
    cycle(1, 0, 0, 32'd0,        1, 32'h104,      32'hA000_0100, 32'h100,      32'h104,      1, 1); // pw=1 iw=0
    cycle(0, 1, 0, 32'd0,        1, 32'h104,      32'd0,         32'd0,        32'd0,        0, 0); // pw=0 iw=1
    cycle(1, 1, 1, 32'hFFFF_FFFF,0, 32'hFFFF_FFFC,32'd0,         32'd0,        32'd0,        0, 1);
    cycle(1, 1, 0, 32'd0,        1, 32'd0,        32'hFFFF_FFFC, 32'hFFFF_FFFC,32'd0,        1, 1); // wrap
    cycle(1, 1, 0, 32'd0,        1, 32'd4,        32'h8C22_0004, 32'd0,        32'd4,        1, 1);

`ifdef IF_STALL_CNT_EN
    check("stall_cnt",  stall_cnt,  32'd2);
    check("bubble_cnt", bubble_cnt, 32'd6);
`endif

    // Asynchronous reset between edges, then a repeated BOOT.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reboot_req", {31'd0, imem_req}, 32'd0);
    cycle(1, 1, 0, 32'd0,        1, 32'd0,        32'd0,         32'd0,        32'd0,        0, 1);
    cycle(1, 1, 0, 32'd0,        1, 32'd4,        32'h8C22_0004, 32'd0,        32'd4,        1, 1);

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: the PC register, next-PC selection and the IF/ID pipeline register.
- Sits directly upstream of the hazard detection unit (HDU) and consumes its PC_Write and IFID_Write outputs.
- Produces the IF/ID Rs/Rt fields that the HDU compares against IDEX_Rt.
- Talks to the instruction memory through a simple request/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h0000_0000, instruction word inserted for bubbles and flushes.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- pc_write  input  1  from HDU PC_Write; 0 holds PC
- ifid_write  input  1  from HDU IFID_Write; 0 holds IF/ID register
- branch_taken  input  1  redirect request from branch resolution
- branch_target  input  32  redirect address
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address
- imem_rdata  input  32  fetched instruction
- imem_ready  input  1  imem_rdata valid for imem_addr this cycle
- ifid_instr  output  32  registered instruction
- ifid_pc  output  32  PC of ifid_instr
- ifid_pc4  output  32  ifid_pc + 4
- ifid_valid  output  1  1 = real instruction, 0 = bubble
- ifid_rs  output  5  ifid_instr[25:21], to HDU IFID_Rs
- ifid_rt  output  5  ifid_instr[20:16], to HDU IFID_Rt

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc=RESET_PC, state=BOOT, imem_req=0.
  - ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, ifid_valid=0.
- State machine:
  - BOOT: exactly one cycle after reset release, imem_req=0, no PC or IF/ID update. Then RUN.
  - RUN: imem_req=1 every cycle.
  - Reset asserted in any state returns immediately to BOOT.
- Address and field outputs:
  - imem_addr = pc (combinational from the PC register) in all states.
  - ifid_rs and ifid_rt are combinational slices of ifid_instr.
- Advance condition: advance = RUN & imem_ready & pc_write & ifid_write.
- Priority per rising edge in RUN, highest first:
  1. branch_taken=1:
     - pc <= {branch_target[31:2], 2'b00}.
     - IF/ID flushed: instr=NOP_INSTR, valid=0, pc/pc4 = 0.
     - Overrides pc_write=0, ifid_write=0 and imem_ready (older branch beats load-use stall).
  2. advance:
     - pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
     - IF/ID <= {imem_rdata, pc, pc+4}, valid=1.
  3. ifid_write=0: IF/ID holds all fields; PC holds.
  4. ifid_write=1 and not advance (imem_ready=0, or pc_write=0): IF/ID loads bubble (NOP_INSTR, valid=0); PC holds.
- No instruction is lost or duplicated: PC and IF/ID move together only on advance.
- Inconsistent HDU combinations: pc_write=1 with ifid_write=0 is treated as a stall (PC holds).
- imem_rdata is ignored whenever imem_ready=0, and in BOOT.
- Latency: instruction at address A appears on ifid_instr one cycle after the edge where A is fetched with imem_ready=1.
- Minimum redirect penalty: one bubble.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - stall_cnt increments each RUN cycle with ifid_write=0 and branch_taken=0.
  - bubble_cnt increments each cycle IF/ID loads a bubble or flush.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset/boot: reset_n=0 then 1, imem_ready=1 with imem_rdata = 32'h8C22_0004 at 0.
  - Cycle 1: imem_req=0, pc=0.
  - Next edge: ifid_instr=32'h8C22_0004, ifid_pc=0, ifid_pc4=4, ifid_valid=1, ifid_rs=1, ifid_rt=2.
- Load-use stall: pc_write=0 and ifid_write=0 for 1 cycle at pc=8.
  - IF/ID and pc=8 held.
  - Next cycle pc=8 refetched, then pc=12; no duplicate ifid_pc.
- Branch during stall: branch_taken=1, branch_target=32'h0000_0103, pc_write=0.
  - Next edge: pc=32'h100, ifid_valid=0, ifid_instr=NOP_INSTR.
- Memory wait: imem_ready=0 for 3 cycles at pc=16 with ifid_write=1.
  - 3 bubbles, pc stays 16.
  - On ready, ifid_pc=16, valid=1.
- Wrap: pc=32'hFFFF_FFFC with advance -> pc=0, ifid_pc4=0.
- Async reset mid-run: reset_n low between edges -> all outputs at reset values without waiting for clk; BOOT repeated on release.
